// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Owns PCF, issues one instruction-memory request at a time, parks a returned
// word while decode is stalled, and resolves decode-stage redirects
// (j, jal, jr, beq, bne). A redirect squashes the wrong-path fetch.
//
// Optional: define FETCH_PERF_CNT_EN to add the perf_* counter outputs.
//
// Ports:
//   clk, rst_n         core clock, synchronous active-low reset
//   StallD             hazard unit freezes IF/ID and PCF
//   BranchD/JumpD/
//   JalD/JrD           decode control for the instruction in InstrD
//   RsDataD, RtDataD   forwarded register values in decode
//   imem_req/addr      request to instruction memory (addr = PCF)
//   imem_ready         request accepted this cycle
//   imem_rvalid/rdata  returned instruction word
//   PCF                current fetch PC
//   InstrD, PCPlus4D,
//   ValidD             IF/ID register contents
//   perf_*_cnt         fetch / redirect / stall counters (optional)

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        JalD,
  input  logic        JrD,
  input  logic [31:0] RsDataD,
  input  logic [31:0] RtDataD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_q, hold_d;

  logic [5:0]  op;
  logic        br_cond;
  logic        taken;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        have_word;
  logic        deliver;
  logic [31:0] fetch_word;

  always_comb begin
    op       = instr_q[31:26];
    br_cond  = ((op == 6'h04) && (RsDataD == RtDataD)) ||
               ((op == 6'h05) && (RsDataD != RtDataD));
    // Redirects are resolved only for a real, non-stalled decode instruction.
    taken    = valid_q & ~StallD & (JrD | JumpD | JalD | (BranchD & br_cond));
    if (JrD) begin
      target = {RsDataD[31:2], 2'b00};
    end else if (JumpD | JalD) begin
      target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    end else begin
      target = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end
    pc_plus4   = pc_q + 32'd4;
    // A word is available either straight from memory in WAIT or parked in HOLD.
    have_word  = ((state_q == S_WAIT) && imem_rvalid) || (state_q == S_HOLD);
    fetch_word = (state_q == S_HOLD) ? hold_q : imem_rdata;
    deliver    = have_word & ~StallD & ~taken;
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    state_d = state_q;

    if (taken) begin
      pc_d    = target;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (deliver) begin
      instr_d = fetch_word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
    end else if (!StallD) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        // A request accepted in the redirect cycle targets the old PC.
        if (imem_ready) state_d = taken ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (taken || deliver) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            hold_d  = imem_rdata;
          end
        end else if (taken) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (taken || deliver) state_d = S_REQ;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= RESET_PC;
      valid_q <= 1'b0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_req  = rst_n & (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign PCF       = pc_q;
  assign InstrD    = instr_q;
  assign PCPlus4D  = pc4_q;
  assign ValidD    = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_evt;

  always_comb begin
    // HOLD with StallD=0 always delivers or redirects, so only the
    // memory-facing states count as starved.
    stall_evt      = StallD | ((state_q != S_HOLD) & ~deliver);
    fetch_cnt_d    = fetch_cnt_q + {31'd0, deliver};
    redirect_cnt_d = redirect_cnt_q + {31'd0, taken};
    stall_cnt_d    = stall_cnt_q + {31'd0, stall_evt};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage

module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        StallD, BranchD, JumpD, JalD, JrD;
  logic [31:0] RsDataD, RtDataD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_stall_cnt;
`endif

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallD      (StallD),
    .BranchD     (BranchD),
    .JumpD       (JumpD),
    .JalD        (JalD),
    .JrD         (JrD),
    .RsDataD     (RsDataD),
    .RtDataD     (RtDataD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_w;
  logic [31:0] exp_pc;
  logic        mon_stall, mon_rst;

  // Delivery monitor: ValidD=1 after an unstalled edge means a fresh word
  // entered IF/ID; it must match the oldest expected {InstrD, PCPlus4D}.
  always @(posedge clk) begin
    mon_stall = StallD;
    mon_rst   = rst_n;
    #1;
    if (mon_rst && !mon_stall && ValidD === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL delivery_unexpected: got InstrD=%h PCPlus4D=%h, required no delivery", InstrD, PCPlus4D);
      end else begin
        exp_w = exp_q.pop_front();
        if ({InstrD, PCPlus4D} !== exp_w) begin
          n_fail++;
          $display("FAIL delivery: got InstrD=%h PCPlus4D=%h, required InstrD=%h PCPlus4D=%h",
                   InstrD, PCPlus4D, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic accept();
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
  endtask

  task automatic ret(input logic [31:0] w);
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
  endtask

  task automatic deliver(input logic [31:0] w);
    accept();
    exp_q.push_back({w, exp_pc + 32'd4});
    ret(w);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; StallD = 0; BranchD = 0; JumpD = 0; JalD = 0; JrD = 0;
    RsDataD = 0; RtDataD = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    cyc();
    cyc();
    n_checks++; if (PCF !== 32'h3000) begin n_fail++; $display("FAIL reset_pcf: got %h required %h", PCF, 32'h3000); end
    n_checks++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h required %h", InstrD, 32'h0); end
    n_checks++; if (PCPlus4D !== 32'h3000) begin n_fail++; $display("FAIL reset_pc4: got %h required %h", PCPlus4D, 32'h3000); end
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", ValidD); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", imem_req); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL first_req: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, 32'h3000); end
    exp_pc = 32'h3000;
  endtask

  task automatic test_fetch();
    accept();
    exp_q.push_back({32'h2008_0005, 32'h3004});
    ret(32'h2008_0005);
    exp_pc = 32'h3004;
    n_checks++; if (PCF !== 32'h3004) begin n_fail++; $display("FAIL fetch_pcf: got %h required %h", PCF, 32'h3004); end
    n_checks++; if (ValidD !== 1'b1 || InstrD !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch_ifid: got valid=%b instr=%h required valid=1 instr=%h", ValidD, InstrD, 32'h2008_0005); end
  endtask

  task automatic test_stall_hold();
    StallD = 1'b1;
    accept();
    ret(32'h0800_0C10);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
      end
      cyc();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b required 0", imem_req); end
      n_checks++; if (PCF !== 32'h3004 || InstrD !== 32'h2008_0005 || ValidD !== 1'b1) begin n_fail++; $display("FAIL hold_frozen: got pcf=%h instr=%h valid=%b required pcf=3004 instr=20080005 valid=1", PCF, InstrD, ValidD); end
    end
    StallD = 1'b0;
    exp_q.push_back({32'h0800_0C10, 32'h3008});
    cyc();
    exp_pc = 32'h3008;
    n_checks++; if (PCF !== 32'h3008 || ValidD !== 1'b1) begin n_fail++; $display("FAIL hold_release: got pcf=%h valid=%b required pcf=3008 valid=1", PCF, ValidD); end
  endtask

  task automatic test_jump();
    JumpD = 1'b1;
    imem_ready = 1'b1;
    cyc();
    JumpD = 1'b0;
    imem_ready = 1'b0;
    n_checks++; if (PCF !== 32'h3040) begin n_fail++; $display("FAIL jump_pcf: got %h required %h", PCF, 32'h3040); end
    n_checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin n_fail++; $display("FAIL jump_squash: got valid=%b instr=%h required valid=0 instr=0", ValidD, InstrD); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL jump_drop_req: got %b required 0", imem_req); end
    ret(32'hDEAD_BEEF);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3040) begin n_fail++; $display("FAIL jump_next_req: got req=%b addr=%h required req=1 addr=3040", imem_req, imem_addr); end
    exp_pc = 32'h3040;
  endtask

  task automatic test_jr();
    deliver(32'h0220_0008);
    StallD = 1'b1;
    accept();
    StallD = 1'b0;
    JrD = 1'b1;
    RsDataD = 32'h0000_3021;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    cyc();
    JrD = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    n_checks++; if (PCF !== 32'h3020 || ValidD !== 1'b0) begin n_fail++; $display("FAIL jr_redirect: got pcf=%h valid=%b required pcf=3020 valid=0", PCF, ValidD); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3020) begin n_fail++; $display("FAIL jr_next_req: got req=%b addr=%h required req=1 addr=3020", imem_req, imem_addr); end
    exp_pc = 32'h3020;
  endtask

  task automatic test_branch();
    deliver(32'h0800_0C03);
    JumpD = 1'b1;
    cyc();
    JumpD = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C) begin n_fail++; $display("FAIL req_redirect: got req=%b addr=%h required req=1 addr=300c", imem_req, imem_addr); end
    exp_pc = 32'h300C;
    deliver(32'h1109_FFFE);
    BranchD = 1'b1; RsDataD = 32'd7; RtDataD = 32'd7;
    cyc();
    BranchD = 1'b0;
    n_checks++; if (PCF !== 32'h3008 || ValidD !== 1'b0) begin n_fail++; $display("FAIL beq_taken: got pcf=%h valid=%b required pcf=3008 valid=0", PCF, ValidD); end
    exp_pc = 32'h3008;
    deliver(32'h1109_FFFE);
    BranchD = 1'b1; RtDataD = 32'd8;
    cyc();
    BranchD = 1'b0;
    n_checks++; if (PCF !== 32'h300C || imem_addr !== 32'h300C) begin n_fail++; $display("FAIL beq_not_taken: got pcf=%h addr=%h required 300c", PCF, imem_addr); end
    deliver(32'h1509_0004);
    n_checks++; if (PCF !== 32'h3010) begin n_fail++; $display("FAIL seq_after_nt: got %h required %h", PCF, 32'h3010); end
    BranchD = 1'b1; RsDataD = 32'd1; RtDataD = 32'd2;
    cyc();
    BranchD = 1'b0;
    n_checks++; if (PCF !== 32'h3020) begin n_fail++; $display("FAIL bne_taken: got %h required %h", PCF, 32'h3020); end
    exp_pc = 32'h3020;
  endtask

  task automatic test_reset_mid_wait();
    accept();
    rst_n = 1'b0;
    cyc();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", imem_req); end
    rst_n = 1'b1;
    n_checks++; if (PCF !== 32'h3000 || ValidD !== 1'b0 || InstrD !== 32'h0) begin n_fail++; $display("FAIL rst_mid_wait: got pcf=%h valid=%b instr=%h required pcf=3000 valid=0 instr=0", PCF, ValidD, InstrD); end
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || ValidD !== 1'b0) begin n_fail++; $display("FAIL late_rvalid: got req=%b addr=%h valid=%b required req=1 addr=3000 valid=0", imem_req, imem_addr, ValidD); end
    exp_pc = 32'h3000;
    deliver(32'h2008_0005);
    n_checks++; if (PCF !== 32'h3004) begin n_fail++; $display("FAIL post_reset_fetch: got %h required %h", PCF, 32'h3004); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall_hold();
    test_jump();
    test_jr();
    test_branch();
    test_reset_mid_wait();
    cyc();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
